// File: rtl/rx_tx_pkg.sv
// Constants and types shared by the GMII transmit and receive paths.
package rx_tx_pkg;

   localparam int          DATA_WIDTH    = 8;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   // Reflected CRC-32; the residue is the raw register value after data plus FCS.
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG
   } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected CRC-32 register for one input byte.
module crc32_d8
   import rx_tx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
      end
   end

endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit framer: preamble, SFD, frame, zero pad, optional FCS, inter-frame gap.
// Define GMII_TX_FCS_EN to generate the CRC-32 FCS here; otherwise upstream supplies it.
module gmii_tx_mac
   import rx_tx_pkg::*;
#(
   parameter int MIN_DATA_BYTES = 60,
   parameter int MAX_DATA_BYTES = 1514,
   parameter int IFG_CYCLES     = 12,
   parameter int PREAMBLE_LEN   = 7
)
(
   input  logic                  switch_clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_valid_i,
   input  logic                  s_last_i,
   output logic                  s_ready_o,
   output logic [7:0]            gmii_tx_data_o,
   output logic                  gmii_tx_en_o,
   output logic                  gmii_tx_er_o,
   output logic                  busy_o,
   output logic [15:0]           frames_sent_o,
   output logic [15:0]           frames_aborted_o
);

   localparam int CNT_W = $clog2(MAX_DATA_BYTES + 5);
`ifdef GMII_TX_FCS_EN
   localparam int PAD_TARGET = MIN_DATA_BYTES;
`else
   localparam int PAD_TARGET = MIN_DATA_BYTES + 4;
`endif
   localparam logic [CNT_W-1:0] PAD_LEN  = CNT_W'(PAD_TARGET);
   localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_DATA_BYTES);
   localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]       IFG_LAST = 8'(IFG_CYCLES - 1);

   tx_state_t        state;
   logic [CNT_W-1:0] byte_cnt;
   logic [CNT_W-1:0] byte_cnt_inc;
   logic [7:0]       step_cnt;

   assign byte_cnt_inc = byte_cnt + CNT_W'(1);
   assign s_ready_o    = (state == DATA) || (state == DRAIN);
   assign busy_o       = (state != IDLE);

`ifdef GMII_TX_FCS_EN
   logic [31:0] crc;
   logic [31:0] crc_next;
   logic [31:0] fcs_word;
   logic [7:0]  crc_byte;

   assign crc_byte = (state == PAD) ? 8'h00 : s_data_i;
   assign fcs_word = ~crc;

   crc32_d8 u_crc32_d8 (
      .crc_in  (crc),
      .data    (crc_byte),
      .crc_out (crc_next)
   );
`endif

   // Outputs are computed one edge ahead: the state names the work done at the edge.
   always_ff @(posedge switch_clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         byte_cnt         <= '0;
         step_cnt         <= '0;
         gmii_tx_data_o   <= '0;
         gmii_tx_en_o     <= 1'b0;
         gmii_tx_er_o     <= 1'b0;
         frames_sent_o    <= '0;
         frames_aborted_o <= '0;
`ifdef GMII_TX_FCS_EN
         crc              <= CRC32_INIT;
`endif
      end else begin
         gmii_tx_data_o <= 8'h00;
         gmii_tx_en_o   <= 1'b0;
         gmii_tx_er_o   <= 1'b0;
         case (state)
            IDLE: begin
               if (s_valid_i) begin
                  gmii_tx_data_o <= PREAMBLE_BYTE;
                  gmii_tx_en_o   <= 1'b1;
                  step_cnt       <= 8'd1;
                  state          <= (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
               end
            end
            PREAMBLE: begin
               gmii_tx_data_o <= PREAMBLE_BYTE;
               gmii_tx_en_o   <= 1'b1;
               step_cnt       <= step_cnt + 8'd1;
               if (step_cnt == PRE_LAST) state <= SFD;
            end
            SFD: begin
               gmii_tx_data_o <= SFD_BYTE;
               gmii_tx_en_o   <= 1'b1;
               byte_cnt       <= '0;
`ifdef GMII_TX_FCS_EN
               crc            <= CRC32_INIT;
`endif
               state          <= DATA;
            end
            DATA: begin
               gmii_tx_en_o <= 1'b1;
               step_cnt     <= '0;
               if (!s_valid_i || byte_cnt == MAX_LEN) begin
                  gmii_tx_er_o     <= 1'b1;
                  frames_aborted_o <= frames_aborted_o + 16'd1;
                  state            <= (s_valid_i && s_last_i) ? IFG : DRAIN;
               end else begin
                  gmii_tx_data_o <= s_data_i;
                  byte_cnt       <= byte_cnt_inc;
`ifdef GMII_TX_FCS_EN
                  crc            <= crc_next;
                  if (s_last_i) state <= (byte_cnt_inc < PAD_LEN) ? PAD : FCS;
`else
                  if (s_last_i) begin
                     if (byte_cnt_inc < PAD_LEN) begin
                        state <= PAD;
                     end else begin
                        state         <= IFG;
                        frames_sent_o <= frames_sent_o + 16'd1;
                     end
                  end
`endif
               end
            end
            PAD: begin
               gmii_tx_en_o <= 1'b1;
               byte_cnt     <= byte_cnt_inc;
               step_cnt     <= '0;
`ifdef GMII_TX_FCS_EN
               crc          <= crc_next;
               if (byte_cnt_inc == PAD_LEN) state <= FCS;
`else
               if (byte_cnt_inc == PAD_LEN) begin
                  state         <= IFG;
                  frames_sent_o <= frames_sent_o + 16'd1;
               end
`endif
            end
`ifdef GMII_TX_FCS_EN
            FCS: begin
               gmii_tx_en_o <= 1'b1;
               case (step_cnt[1:0])
                  2'd0:    gmii_tx_data_o <= fcs_word[7:0];
                  2'd1:    gmii_tx_data_o <= fcs_word[15:8];
                  2'd2:    gmii_tx_data_o <= fcs_word[23:16];
                  default: gmii_tx_data_o <= fcs_word[31:24];
               endcase
               step_cnt <= step_cnt + 8'd1;
               if (step_cnt[1:0] == 2'd3) begin
                  step_cnt      <= '0;
                  frames_sent_o <= frames_sent_o + 16'd1;
                  state         <= IFG;
               end
            end
`endif
            DRAIN: begin
               step_cnt <= '0;
               if (s_valid_i && s_last_i) state <= IFG;
            end
            IFG: begin
               step_cnt <= step_cnt + 8'd1;
               if (step_cnt == IFG_LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Directed self-checking bench for gmii_tx_mac; follows GMII_TX_FCS_EN like the design.
module tb_gmii_tx_mac;

`ifdef GMII_TX_FCS_EN
   localparam int PAD_TGT = 60;
`else
   localparam int PAD_TGT = 64;
`endif

   logic        switch_clk;
   logic        rst;
   logic [7:0]  s_data_i;
   logic        s_valid_i;
   logic        s_last_i;
   logic        s_ready_o;
   logic [7:0]  gmii_tx_data_o;
   logic        gmii_tx_en_o;
   logic        gmii_tx_er_o;
   logic        busy_o;
   logic [15:0] frames_sent_o;
   logic [15:0] frames_aborted_o;

   logic [31:0] cu_in;
   logic [7:0]  cu_data;
   logic [31:0] cu_out;

   int          checks = 0;
   int          failures = 0;

   logic [7:0]  frm[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  obs_q[$];
   int          gap_q[$];
   int          en_cycles = 0;
   int          er_cnt = 0;
   int          idle_run = 0;
   bit          seen = 0;

   gmii_tx_mac dut (
      .switch_clk       (switch_clk),
      .rst              (rst),
      .s_data_i         (s_data_i),
      .s_valid_i        (s_valid_i),
      .s_last_i         (s_last_i),
      .s_ready_o        (s_ready_o),
      .gmii_tx_data_o   (gmii_tx_data_o),
      .gmii_tx_en_o     (gmii_tx_en_o),
      .gmii_tx_er_o     (gmii_tx_er_o),
      .busy_o           (busy_o),
      .frames_sent_o    (frames_sent_o),
      .frames_aborted_o (frames_aborted_o)
   );

   crc32_d8 u_crc_unit (
      .crc_in  (cu_in),
      .data    (cu_data),
      .crc_out (cu_out)
   );

   initial begin
      switch_clk = 1'b0;
      forever #5 switch_clk = ~switch_clk;
   end

   always @(negedge switch_clk) begin
      if (gmii_tx_en_o) begin
         if (gmii_tx_er_o) er_cnt++;
         else obs_q.push_back(gmii_tx_data_o);
         en_cycles++;
         if (seen && idle_run > 0) gap_q.push_back(idle_run);
         seen     = 1;
         idle_run = 0;
      end else begin
         idle_run++;
      end
   end

   function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
      logic fb;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ d[i];
         c  = {1'b0, c[31:1]};
         if (fb) c = c ^ 32'hEDB88320;
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic make_hdr();
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(8'hFF);
      for (int i = 0; i < 5; i++) frm.push_back(8'h00);
      frm.push_back(8'h01);
      frm.push_back(8'h08);
      frm.push_back(8'h00);
   endtask

   task automatic make_frame(input int n);
      make_hdr();
      for (int i = 14; i < n; i++) frm.push_back(8'((i * 7 + 3) & 255));
   endtask

   task automatic exp_preamble();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
   endtask

   task automatic build_exp(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      exp_preamble();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(frm[i]);
         c = crc_bits(c, frm[i]);
      end
      for (int i = n; i < PAD_TGT; i++) begin
         exp_q.push_back(8'h00);
         c = crc_bits(c, 8'h00);
      end
`ifdef GMII_TX_FCS_EN
      c = ~c;
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[23:16]);
      exp_q.push_back(c[31:24]);
`endif
   endtask

   task automatic clear_obs();
      exp_q.delete();
      obs_q.delete();
      en_cycles = 0;
      er_cnt    = 0;
   endtask

   // Byte is consumed at the rising edge following a negedge with ready high.
   task automatic drive_byte(input logic [7:0] d, input logic l);
      logic accepted;
      int   g;
      accepted  = 1'b0;
      g         = 0;
      s_valid_i = 1'b1;
      s_data_i  = d;
      s_last_i  = l;
      while (!accepted && g < 200) begin
         @(negedge switch_clk);
         accepted = s_ready_o;
         @(posedge switch_clk);
         #1;
         g++;
      end
      if (!accepted) check("handshake_timeout", 32'(accepted), 32'd1);
   endtask

   task automatic send_range(input int from, input int to, input int n);
      for (int i = from; i < to; i++) drive_byte(frm[i], (i == n - 1));
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      do begin
         @(negedge switch_clk);
         g++;
      end while (busy_o && g < 3000);
      if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
   endtask

   task automatic compare_stream(input string tag);
      int n;
      int idx;
      check({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n   = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      idx = n - 1;
      for (int i = 0; i < n; i++) begin
         if (obs_q[i] !== exp_q[i]) begin
            idx = i;
            break;
         end
      end
      if (n > 0) check({tag, "_byte"}, 32'(obs_q[idx]), 32'(exp_q[idx]));
   endtask

   initial begin
      logic [31:0] c;
      string       s;
      rst       = 1'b1;
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      s_data_i  = 8'h00;
      cu_in     = 32'hFFFFFFFF;
      cu_data   = 8'h00;

      // CRC sub-block against the standard "123456789" check value.
      s = "123456789";
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) begin
         cu_in   = c;
         cu_data = s[i];
         #1;
         c = cu_out;
      end
      check("crc_unit_check", ~c, 32'hCBF43926);

      check("rst_data",    32'(gmii_tx_data_o),   32'd0);
      check("rst_en",      32'(gmii_tx_en_o),     32'd0);
      check("rst_er",      32'(gmii_tx_er_o),     32'd0);
      check("rst_ready",   32'(s_ready_o),        32'd0);
      check("rst_busy",    32'(busy_o),           32'd0);
      check("rst_sent",    32'(frames_sent_o),    32'd0);
      check("rst_aborted", 32'(frames_aborted_o), 32'd0);
      repeat (3) @(posedge switch_clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge switch_clk);
      #1;

      // 60-byte frame: DA broadcast, SA ..01, IPv4 type, 46-byte payload.
      clear_obs();
      make_hdr();
      for (int i = 0; i < 46; i++) frm.push_back(8'(i));
      build_exp(60);
      send_range(0, 60, 60);
      wait_idle();
      compare_stream("f64");
      check("f64_en_cycles", 32'(en_cycles), 32'd72);
      check("f64_er", 32'(er_cnt), 32'd0);
      check("f64_sent", 32'(frames_sent_o), 32'd1);
`ifdef GMII_TX_FCS_EN
      c = 32'hFFFFFFFF;
      for (int i = 8; i < obs_q.size(); i++) c = crc_bits(c, obs_q[i]);
      check("f64_residue", c, 32'hDEBB20E3);
`endif

      // Short frame padded with zeros.
      clear_obs();
      make_hdr();
      frm.push_back(8'h11);
      frm.push_back(8'h22);
      frm.push_back(8'h33);
      frm.push_back(8'h44);
      build_exp(18);
      send_range(0, 18, 18);
      wait_idle();
      compare_stream("f18");
      check("f18_en_cycles", 32'(en_cycles), 32'd72);
      check("f18_sent", 32'(frames_sent_o), 32'd2);

      // Two frames queued back-to-back.
      clear_obs();
      gap_q.delete();
      seen = 0;
      make_frame(64);
      build_exp(64);
      send_range(0, 64, 64);
      make_frame(70);
      build_exp(70);
      send_range(0, 70, 70);
      wait_idle();
      compare_stream("b2b");
      check("b2b_gap_count", 32'(gap_q.size()), 32'd1);
      if (gap_q.size() > 0) check("b2b_gap", 32'(gap_q[0]), 32'd12);
      check("b2b_sent", 32'(frames_sent_o), 32'd4);

      // Underflow after byte 20.
      clear_obs();
      make_frame(40);
      exp_preamble();
      for (int i = 0; i < 20; i++) exp_q.push_back(frm[i]);
      for (int i = 0; i < 20; i++) drive_byte(frm[i], 1'b0);
      s_valid_i = 1'b0;
      @(posedge switch_clk);
      #1;
      send_range(20, 40, 40);
      wait_idle();
      compare_stream("underflow");
      check("underflow_er", 32'(er_cnt), 32'd1);
      check("underflow_en_cycles", 32'(en_cycles), 32'd29);
      check("underflow_aborted", 32'(frames_aborted_o), 32'd1);
      check("underflow_sent", 32'(frames_sent_o), 32'd4);

      // Oversize: 1520 bytes, abort on byte 1515.
      clear_obs();
      make_frame(1520);
      exp_preamble();
      for (int i = 0; i < 1514; i++) exp_q.push_back(frm[i]);
      send_range(0, 1520, 1520);
      wait_idle();
      compare_stream("oversize");
      check("oversize_er", 32'(er_cnt), 32'd1);
      check("oversize_aborted", 32'(frames_aborted_o), 32'd2);
      check("oversize_sent", 32'(frames_sent_o), 32'd4);

      // Asynchronous reset in the middle of DATA.
      make_frame(64);
      for (int i = 0; i < 10; i++) drive_byte(frm[i], 1'b0);
      #2 rst = 1'b1;
      s_valid_i = 1'b0;
      #1;
      check("midrst_en", 32'(gmii_tx_en_o), 32'd0);
      check("midrst_data", 32'(gmii_tx_data_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_ready", 32'(s_ready_o), 32'd0);
      check("midrst_sent", 32'(frames_sent_o), 32'd0);
      check("midrst_aborted", 32'(frames_aborted_o), 32'd0);
      repeat (2) @(posedge switch_clk);
      #1 rst = 1'b0;
      @(posedge switch_clk);
      #1;
      clear_obs();
      make_hdr();
      frm.push_back(8'hA1);
      frm.push_back(8'hB2);
      frm.push_back(8'hC3);
      build_exp(17);
      send_range(0, 17, 17);
      wait_idle();
      compare_stream("post_rst");
      check("post_rst_sent", 32'(frames_sent_o), 32'd1);
      check("post_rst_aborted", 32'(frames_aborted_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
